// File: rtl/rvx_dma_copy.sv
// rtl/rvx_dma_copy.sv - word-at-a-time copy/fill initiator for the RVX memory bus
// One bus transaction outstanding at a time; all bus and status outputs are registered.
module rvx_dma_copy #(
  parameter int LENGTH_WIDTH = 16
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    fill_mode,
  input  logic [31:0]             src_address,
  input  logic [31:0]             dst_address,
  input  logic [LENGTH_WIDTH-1:0] length,
  input  logic [31:0]             fill_pattern,
  input  logic                    abort,
  output logic                    busy,
  output logic                    done,
  output logic                    aborted,
  output logic [LENGTH_WIDTH-1:0] words_done,
  output logic [31:0]             rw_address,
  input  logic [31:0]             read_data,
  output logic                    read_request,
  input  logic                    read_response,
  output logic [31:0]             write_data,
  output logic [3:0]              write_strobe,
  output logic                    write_request,
  input  logic                    write_response
);

  typedef enum logic [2:0] {
    IDLE,
    READ_REQ,
    READ_WAIT,
    WRITE_REQ,
    WRITE_WAIT,
    DONE
  } state_t;

  state_t                  state_q;
  logic [29:0]             src_ptr_q;
  logic [29:0]             dst_ptr_q;
  logic [LENGTH_WIDTH-1:0] remaining_q;
  logic [LENGTH_WIDTH-1:0] words_done_q;
  logic                    fill_q;
  logic [31:0]             fill_pattern_q;
  logic                    abort_pend_q;
  logic                    busy_q;
  logic                    done_q;
  logic                    aborted_q;
  logic                    read_request_q;
  logic                    write_request_q;
  logic [31:0]             rw_address_q;
  logic [31:0]             write_data_q;
  logic [3:0]              write_strobe_q;

  logic [29:0]             src_ptr_d;
  logic [29:0]             dst_ptr_d;
  logic                    finish_d;
  logic                    unused_addr_bits;

  assign src_ptr_d = src_ptr_q + 30'd1;
  assign dst_ptr_d = dst_ptr_q + 30'd1;
  // The word finishing in WRITE_WAIT is the last one, or an abort was seen while busy.
  assign finish_d  = (remaining_q == LENGTH_WIDTH'(1)) || abort_pend_q || abort;
  assign unused_addr_bits = ^{src_address[1:0], dst_address[1:0]};

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q         <= IDLE;
      src_ptr_q       <= '0;
      dst_ptr_q       <= '0;
      remaining_q     <= '0;
      words_done_q    <= '0;
      fill_q          <= 1'b0;
      fill_pattern_q  <= '0;
      abort_pend_q    <= 1'b0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
      aborted_q       <= 1'b0;
      read_request_q  <= 1'b0;
      write_request_q <= 1'b0;
      rw_address_q    <= '0;
      write_data_q    <= '0;
      write_strobe_q  <= 4'h0;
    end else begin
      read_request_q  <= 1'b0;
      write_request_q <= 1'b0;
      if (busy_q && abort) begin
        abort_pend_q <= 1'b1;
      end

      case (state_q)
        IDLE: begin
          if (start) begin
            src_ptr_q      <= src_address[31:2];
            dst_ptr_q      <= dst_address[31:2];
            remaining_q    <= length;
            fill_q         <= fill_mode;
            fill_pattern_q <= fill_pattern;
            words_done_q   <= '0;
            aborted_q      <= 1'b0;
            abort_pend_q   <= 1'b0;
            busy_q         <= 1'b1;
            if (length == '0) begin
              // done stays low here so the pulse lands one cycle later
              state_q <= DONE;
            end else if (fill_mode) begin
              state_q         <= WRITE_REQ;
              write_request_q <= 1'b1;
              rw_address_q    <= {dst_address[31:2], 2'b00};
              write_data_q    <= fill_pattern;
              write_strobe_q  <= 4'hF;
            end else begin
              state_q        <= READ_REQ;
              read_request_q <= 1'b1;
              rw_address_q   <= {src_address[31:2], 2'b00};
            end
          end
        end

        READ_REQ: begin
          state_q <= READ_WAIT;
        end

        READ_WAIT: begin
          if (read_response) begin
            state_q         <= WRITE_REQ;
            write_request_q <= 1'b1;
            rw_address_q    <= {dst_ptr_q, 2'b00};
            write_data_q    <= read_data;
            write_strobe_q  <= 4'hF;
          end
        end

        WRITE_REQ: begin
          state_q <= WRITE_WAIT;
        end

        WRITE_WAIT: begin
          if (write_response) begin
            words_done_q <= words_done_q + LENGTH_WIDTH'(1);
            remaining_q  <= remaining_q - LENGTH_WIDTH'(1);
            src_ptr_q    <= src_ptr_d;
            dst_ptr_q    <= dst_ptr_d;
            if (finish_d) begin
              state_q        <= DONE;
              done_q         <= 1'b1;
              aborted_q      <= abort_pend_q || abort;
              rw_address_q   <= '0;
              write_data_q   <= '0;
              write_strobe_q <= 4'h0;
            end else if (fill_q) begin
              state_q         <= WRITE_REQ;
              write_request_q <= 1'b1;
              rw_address_q    <= {dst_ptr_d, 2'b00};
              write_data_q    <= fill_pattern_q;
              write_strobe_q  <= 4'hF;
            end else begin
              state_q        <= READ_REQ;
              read_request_q <= 1'b1;
              rw_address_q   <= {src_ptr_d, 2'b00};
              write_data_q   <= '0;
              write_strobe_q <= 4'h0;
            end
          end
        end

        DONE: begin
          if (done_q) begin
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            done_q <= 1'b1;
          end
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign aborted       = aborted_q;
  assign words_done    = words_done_q;
  assign rw_address    = rw_address_q;
  assign read_request  = read_request_q;
  assign write_data    = write_data_q;
  assign write_strobe  = write_strobe_q;
  assign write_request = write_request_q;

endmodule

// File: tb/tb_rvx_dma_copy.sv
// tb/tb_rvx_dma_copy.sv - directed bench for rvx_dma_copy with a latency-programmable RAM responder
module tb_rvx_dma_copy;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        fill_mode = 1'b0;
  logic [31:0] src_address = '0;
  logic [31:0] dst_address = '0;
  logic [15:0] length = '0;
  logic [31:0] fill_pattern = '0;
  logic        abort = 1'b0;
  logic        busy;
  logic        done;
  logic        aborted;
  logic [15:0] words_done;
  logic [31:0] rw_address;
  logic [31:0] read_data = '0;
  logic        read_request;
  logic        read_response = 1'b0;
  logic [31:0] write_data;
  logic [3:0]  write_strobe;
  logic        write_request;
  logic        write_response = 1'b0;

  rvx_dma_copy #(.LENGTH_WIDTH(16)) dut (
    .clock(clock), .reset(reset), .start(start), .fill_mode(fill_mode),
    .src_address(src_address), .dst_address(dst_address), .length(length),
    .fill_pattern(fill_pattern), .abort(abort), .busy(busy), .done(done),
    .aborted(aborted), .words_done(words_done), .rw_address(rw_address),
    .read_data(read_data), .read_request(read_request), .read_response(read_response),
    .write_data(write_data), .write_strobe(write_strobe), .write_request(write_request),
    .write_response(write_response)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // RAM: unwritten words read back a fixed address-derived background value
  logic [31:0] wmem [0:1023];
  bit          written [0:1023];
  int          lat = 1;
  int          rd_cnt = 0;
  int          wr_cnt = 0;
  logic [31:0] rd_addr = '0;
  logic [31:0] wr_addr = '0;
  logic [31:0] wr_data = '0;
  int          n_rd = 0;
  int          n_wr = 0;

  function automatic logic [31:0] dflt(input logic [31:0] a);
    logic [31:0] w;
    w = {a[31:2], 2'b00};
    if (w >= 32'h100 && w <= 32'h124) return ((w - 32'h100) / 4 + 1) * 32'h11111111;
    return 32'hCAFE0000 | {16'h0, w[15:0]};
  endfunction

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (written[a[11:2]]) return wmem[a[11:2]];
    return dflt(a);
  endfunction

  always @(negedge clock) begin
    read_response  = 1'b0;
    write_response = 1'b0;
    if (rd_cnt > 0) begin
      rd_cnt--;
      if (rd_cnt == 0) begin
        read_response = 1'b1;
        read_data     = mem_rd(rd_addr);
      end
    end
    if (wr_cnt > 0) begin
      wr_cnt--;
      if (wr_cnt == 0) begin
        write_response = 1'b1;
        wmem[wr_addr[11:2]]    = wr_data;
        written[wr_addr[11:2]] = 1'b1;
      end
    end
    if (read_request === 1'b1) begin
      rd_cnt  = lat;
      rd_addr = rw_address;
      n_rd++;
    end
    if (write_request === 1'b1) begin
      wr_cnt  = lat;
      wr_addr = rw_address;
      wr_data = write_data;
      n_wr++;
    end
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic do_start(input logic [31:0] s, input logic [31:0] d, input logic [15:0] n,
                          input logic f, input logic [31:0] p, output int t);
    @(negedge clock);
    src_address  = s;
    dst_address  = d;
    length       = n;
    fill_mode    = f;
    fill_pattern = p;
    start        = 1'b1;
    t            = cyc;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic wait_done(output int c);
    c = -1;
    for (int i = 0; i < 300; i++) begin
      if (done === 1'b1) begin
        c = cyc;
        break;
      end
      @(negedge clock);
    end
  endtask

  int t0;
  int tdone;
  int rd0;
  int wr0;

  initial begin
    repeat (3) @(negedge clock);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_aborted", {31'd0, aborted}, 32'd0);
    check("rst_reqs", {30'd0, read_request, write_request}, 32'd0);
    check("rst_bus", rw_address | write_data | {28'd0, write_strobe}, 32'd0);
    check("rst_words", {16'd0, words_done}, 32'd0);
    reset = 1'b0;
    @(negedge clock);

    // 4-word copy 0x100 -> 0x200
    do_start(32'h100, 32'h200, 16'd4, 1'b0, 32'h0, t0);
    check("cp_busy_t1", {31'd0, busy}, 32'd1);
    check("cp_rreq_t1", {31'd0, read_request}, 32'd1);
    check("cp_addr_t1", rw_address, 32'h100);
    @(negedge clock);
    check("cp_rreq_t2", {31'd0, read_request}, 32'd0);
    check("cp_addr_t2", rw_address, 32'h100);
    @(negedge clock);
    check("cp_wreq_t3", {31'd0, write_request}, 32'd1);
    check("cp_waddr_t3", rw_address, 32'h200);
    check("cp_wdata_t3", write_data, 32'h11111111);
    check("cp_strb_t3", {28'd0, write_strobe}, 32'hF);
    wait_done(tdone);
    check("cp_done_cyc", tdone - t0, 32'd17);
    check("cp_words", {16'd0, words_done}, 32'd4);
    check("cp_aborted", {31'd0, aborted}, 32'd0);
    @(negedge clock);
    check("cp_busy_end", {31'd0, busy}, 32'd0);
    check("cp_done_end", {31'd0, done}, 32'd0);
    for (int i = 0; i < 4; i++) check("cp_mem", mem_rd(32'h200 + 4 * i), 32'h11111111 * (i + 1));

    // 3-word fill at 0x40
    rd0 = n_rd;
    wr0 = n_wr;
    do_start(32'h0, 32'h40, 16'd3, 1'b1, 32'hDEADBEEF, t0);
    check("fl_wreq_t1", {31'd0, write_request}, 32'd1);
    check("fl_wdata_t1", write_data, 32'hDEADBEEF);
    wait_done(tdone);
    check("fl_done_cyc", tdone - t0, 32'd7);
    check("fl_words", {16'd0, words_done}, 32'd3);
    check("fl_nreads", n_rd - rd0, 32'd0);
    check("fl_nwrites", n_wr - wr0, 32'd3);
    for (int i = 0; i < 3; i++) check("fl_mem", mem_rd(32'h40 + 4 * i), 32'hDEADBEEF);
    check("fl_mem_past", mem_rd(32'h4C), 32'hCAFE004C);

    // zero-length transfer
    rd0 = n_rd;
    wr0 = n_wr;
    do_start(32'h100, 32'h700, 16'd0, 1'b0, 32'h0, t0);
    check("z_busy_t1", {31'd0, busy}, 32'd1);
    check("z_done_t1", {31'd0, done}, 32'd0);
    wait_done(tdone);
    check("z_done_cyc", tdone - t0, 32'd2);
    check("z_words", {16'd0, words_done}, 32'd0);
    @(negedge clock);
    check("z_busy_end", {31'd0, busy}, 32'd0);
    check("z_traffic", (n_rd - rd0) + (n_wr - wr0), 32'd0);

    // 10-word copy aborted during the read of word 2
    do_start(32'h100, 32'h300, 16'd10, 1'b0, 32'h0, t0);
    repeat (9) @(negedge clock);
    abort = 1'b1;
    @(negedge clock);
    abort = 1'b0;
    wait_done(tdone);
    check("ab_done_cyc", tdone - t0, 32'd13);
    check("ab_aborted", {31'd0, aborted}, 32'd1);
    check("ab_words", {16'd0, words_done}, 32'd3);
    check("ab_mem2", mem_rd(32'h308), 32'h33333333);
    check("ab_mem3", mem_rd(32'h30C), 32'hCAFE030C);

    // unaligned addresses, start while busy ignored
    do_start(32'h103, 32'h1FE, 16'd1, 1'b0, 32'h0, t0);
    check("ua_aborted_clr", {31'd0, aborted}, 32'd0);
    check("ua_raddr", rw_address, 32'h100);
    src_address  = 32'h400;
    dst_address  = 32'h800;
    length       = 16'd7;
    fill_mode    = 1'b1;
    fill_pattern = 32'h55AA55AA;
    start        = 1'b1;
    @(negedge clock);
    start = 1'b0;
    @(negedge clock);
    check("ua_wreq", {31'd0, write_request}, 32'd1);
    check("ua_waddr", rw_address, 32'h1FC);
    check("ua_wdata", write_data, 32'h11111111);
    wait_done(tdone);
    check("ua_done_cyc", tdone - t0, 32'd5);
    check("ua_words", {16'd0, words_done}, 32'd1);
    check("ua_mem", mem_rd(32'h1FC), 32'h11111111);
    check("ua_no_restart", mem_rd(32'h800), 32'hCAFE0800);

    // 5-cycle responder, reset during WRITE_WAIT, then a clean restart
    lat = 5;
    do_start(32'h100, 32'h500, 16'd2, 1'b0, 32'h0, t0);
    repeat (8) @(negedge clock);
    check("rs_waddr_ww", rw_address, 32'h500);
    check("rs_strb_ww", {28'd0, write_strobe}, 32'hF);
    reset = 1'b1;
    #1;
    check("rs_busy", {31'd0, busy}, 32'd0);
    check("rs_bus", rw_address | write_data | {28'd0, write_strobe}, 32'd0);
    check("rs_reqs", {29'd0, read_request, write_request, done}, 32'd0);
    @(negedge clock);
    reset = 1'b0;
    repeat (4) @(negedge clock);
    check("rs_late_busy", {31'd0, busy}, 32'd0);
    check("rs_late_out", {29'd0, read_request, write_request, done}, 32'd0);
    check("rs_late_words", {16'd0, words_done}, 32'd0);
    do_start(32'h100, 32'h600, 16'd2, 1'b0, 32'h0, t0);
    wait_done(tdone);
    check("rs_done_cyc", tdone - t0, 32'd25);
    check("rs_words", {16'd0, words_done}, 32'd2);
    check("rs_mem0", mem_rd(32'h600), 32'h11111111);
    check("rs_mem1", mem_rd(32'h604), 32'h22222222);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
